// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver with a single-entry holding register
// and sticky framing/overrun status for the SoC UART peripheral.
module uart_rx_unit #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_i,
    input  logic       Rx_Clr_i,
    output logic [7:0] Rx_Data_o,
    output logic       Rx_Valid_o,
    output logic       Frame_Err_o,
    output logic       Overrun_o,
    output logic       Busy_o
);
    localparam int BIT_TICKS  = CLK_FREQ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CW         = $clog2(BIT_TICKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          w_fall;
    logic          w_tick;
    logic          w_start_ok;
    logic          w_bit_smp;
    logic          w_stop_good;
    logic          w_stop_bad;

    // Edge-only start detection: a held-low line never retriggers.
    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= Rx_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) w_next = S_START;
            end
            S_START: begin
                if (r_cnt == HALF_LAST)
                    w_next = r_sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST && r_idx == 3'd7)
                    w_next = S_STOP;
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy_o      = (r_state != S_IDLE);
        w_tick      = 1'b0;
        w_start_ok  = 1'b0;
        w_bit_smp   = 1'b0;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        unique case (r_state)
            S_START: begin
                w_tick     = (r_cnt == HALF_LAST);
                w_start_ok = w_tick & ~r_sync2;
            end
            S_DATA: begin
                w_tick    = (r_cnt == BIT_LAST);
                w_bit_smp = w_tick;
            end
            S_STOP: begin
                w_tick      = (r_cnt == BIT_LAST);
                w_stop_good = w_tick & r_sync2;
                w_stop_bad  = w_tick & ~r_sync2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == S_IDLE || w_tick) r_cnt <= '0;
            else                             r_cnt <= r_cnt + CW'(1);
            if (w_start_ok)     r_idx <= '0;
            else if (w_bit_smp) r_idx <= r_idx + 3'd1;
            if (w_bit_smp) r_shift <= {r_sync2, r_shift[7:1]};
        end
    end

    // A stop-sample update beats a same-cycle clear for the flag it sets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Rx_Data_o   <= 8'h00;
            Rx_Valid_o  <= 1'b0;
            Frame_Err_o <= 1'b0;
            Overrun_o   <= 1'b0;
        end else begin
            if (w_stop_good) begin
                Rx_Data_o  <= r_shift;
                Rx_Valid_o <= 1'b1;
            end else if (Rx_Clr_i) begin
                Rx_Valid_o <= 1'b0;
            end
            if (w_stop_bad)    Frame_Err_o <= 1'b1;
            else if (Rx_Clr_i) Frame_Err_o <= 1'b0;
            if (w_stop_good && Rx_Valid_o && !Rx_Clr_i)
                Overrun_o <= 1'b1;
            else if (Rx_Clr_i)
                Overrun_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit: directed 8N1 frames, expected
// status queued at issue, checked whenever Busy_o falls.
module tb_uart_rx_unit;
    localparam int BT  = 434;
    localparam int LAT = 4126;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Rx_i = 1'b1;
    logic       Rx_Clr_i = 1'b0;
    logic [7:0] Rx_Data_o;
    logic       Rx_Valid_o;
    logic       Frame_Err_o;
    logic       Overrun_o;
    logic       Busy_o;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       fe;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    logic pb = 1'b0;

    uart_rx_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Rx_i       (Rx_i),
        .Rx_Clr_i   (Rx_Clr_i),
        .Rx_Data_o  (Rx_Data_o),
        .Rx_Valid_o (Rx_Valid_o),
        .Frame_Err_o(Frame_Err_o),
        .Overrun_o  (Overrun_o),
        .Busy_o     (Busy_o)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic v,
                        input logic fe, input logic ov, input int c);
        exp_t e;
        e.d = d; e.v = v; e.fe = fe; e.ov = ov; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic tx(input logic [7:0] d, input logic stop,
                      input int ticks);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            Rx_i = f[i];
            repeat (ticks) @(posedge clk);
            #1;
        end
        Rx_i = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input logic stop,
                         input int ticks, input logic [7:0] ed,
                         input logic ev, input logic efe, input logic eov);
        push(ed, ev, efe, eov, cyc + LAT);
        tx(d, stop, ticks);
    endtask

    task automatic clr_pulse();
        Rx_Clr_i = 1'b1;
        @(posedge clk);
        #1;
        Rx_Clr_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (pb && !Busy_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_busy_fall", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("data", 32'(Rx_Data_o), 32'(e.d));
                    chk("valid", 32'(Rx_Valid_o), 32'(e.v));
                    chk("frame_err", 32'(Frame_Err_o), 32'(e.fe));
                    chk("overrun", 32'(Overrun_o), 32'(e.ov));
                    if (e.cyc >= 0) begin
                        tests++;
                        if (cyc < e.cyc - 3 || cyc > e.cyc + 3) begin
                            failed++;
                            $display("FAIL latency: got cycle %0d expected %0d +-3",
                                     cyc, e.cyc);
                        end
                    end
                end
            end
            pb = Busy_o;
        end
    end

    initial begin : stim
        int n0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(Rx_Data_o), 32'h00);
        chk("rst_valid", 32'(Rx_Valid_o), 32'h0);
        chk("rst_fe", 32'(Frame_Err_o), 32'h0);
        chk("rst_ov", 32'(Overrun_o), 32'h0);
        chk("rst_busy", 32'(Busy_o), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(10);

        // glitch: low 100 clocks, sample at start midpoint sees high
        n0 = cyc;
        push(8'h00, 1'b0, 1'b0, 1'b0, n0 + 220);
        Rx_i = 1'b0;
        idle(2);
        chk("glitch_busy_pre", 32'(Busy_o), 32'h0);
        idle(1);
        chk("glitch_busy_rise", 32'(Busy_o), 32'h1);
        idle(97);
        Rx_i = 1'b1;
        idle(300);

        frame(8'h3C, 1'b0, BT, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(50);
        clr_pulse();
        @(negedge clk);
        chk("fe_cleared", 32'(Frame_Err_o), 32'h0);
        idle(20);

        // clear mid-frame must not disturb reception
        fork
            frame(8'hA5, 1'b1, BT, 8'hA5, 1'b1, 1'b0, 1'b0);
            begin idle(2000); clr_pulse(); end
        join
        idle(20);
        clr_pulse();
        @(negedge clk);
        chk("a5_valid_cleared", 32'(Rx_Valid_o), 32'h0);
        idle(20);

        frame(8'h11, 1'b1, BT, 8'h11, 1'b1, 1'b0, 1'b0);
        frame(8'h22, 1'b1, BT, 8'h22, 1'b1, 1'b0, 1'b1);
        idle(20);
        clr_pulse();
        @(negedge clk);
        chk("ov_cleared", 32'(Overrun_o), 32'h0);
        chk("ov_valid_cleared", 32'(Rx_Valid_o), 32'h0);
        idle(20);

        // clear lands on the same edge as the second load
        n0 = cyc;
        fork
            begin
                frame(8'h11, 1'b1, BT, 8'h11, 1'b1, 1'b0, 1'b0);
                frame(8'h22, 1'b1, BT, 8'h22, 1'b1, 1'b0, 1'b0);
            end
            begin
                wait (cyc == n0 + 10 * BT + LAT - 1);
                #1;
                clr_pulse();
            end
        join
        idle(20);

        // reset during bit 4 of 0xFF while 0x22 is held valid
        Rx_i = 1'b0;
        idle(BT);
        Rx_i = 1'b1;
        idle(4 * BT + 200);
        push(8'h00, 1'b0, 1'b0, 1'b0, -1);
        rst = 1'b0;
        #1;
        chk("mrst_data", 32'(Rx_Data_o), 32'h00);
        chk("mrst_valid", 32'(Rx_Valid_o), 32'h0);
        chk("mrst_busy", 32'(Busy_o), 32'h0);
        idle(3);
        rst = 1'b1;
        idle(10 * BT);
        chk("mrst_quiet", 32'(Busy_o), 32'h0);
        frame(8'h5A, 1'b1, BT, 8'h5A, 1'b1, 1'b0, 1'b0);
        idle(20);
        clr_pulse();
        idle(20);

        frame(8'hC3, 1'b1, 425, 8'hC3, 1'b1, 1'b0, 1'b0);
        clr_pulse();
        idle(20);
        frame(8'h3C, 1'b1, 443, 8'h3C, 1'b1, 1'b0, 1'b0);
        clr_pulse();
        idle(20);

        // loopback stream, each byte acknowledged shortly after load
        n0 = cyc;
        fork
            begin
                frame(8'h00, 1'b1, BT, 8'h00, 1'b1, 1'b0, 1'b0);
                frame(8'hFF, 1'b1, BT, 8'hFF, 1'b1, 1'b0, 1'b0);
                frame(8'h55, 1'b1, BT, 8'h55, 1'b1, 1'b0, 1'b0);
                frame(8'hAA, 1'b1, BT, 8'hAA, 1'b1, 1'b0, 1'b0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    wait (cyc == n0 + i * 10 * BT + LAT + 5);
                    #1;
                    clr_pulse();
                end
            end
        join
        idle(100);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
